// File: rtl/usb_tx_lsfs.sv
// usb_tx_lsfs: USB low-/full-speed serial transmitter.
// Sends SYNC, a stream of bytes, an optional CRC16 and EOP, with NRZI
// encoding and bit stuffing applied to everything between SYNC and EOP.
// Bytes are pulled with a valid/ready handshake in the last clk of the bit
// that precedes each byte. Running out of bytes ends the packet.

module usb_tx_lsfs #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit CRC16_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       low_speed,
  input  logic       crc16,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic [1:0] d_o,
  output logic       d_en
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC  = 3'd3,
    ST_EOP  = 3'd4
  } state_t;

  // Last clk index of a bit time in each speed mode
  localparam logic [7:0]  FS_LAST       = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  LS_LAST       = 8'(8 * CLKS_PER_BIT - 1);
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  // x^16+x^15+x^2+1 in bit-reversed form, so the register is LSB-first
  localparam logic [15:0] CRC_POLY_REFL = 16'hA001;
  localparam logic [2:0]  STUFF_RUN     = 3'd6;

  // One serial step of the LSB-first CRC16
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                             input logic        din);
    logic fb;
    fb = crc_in[0] ^ din;
    crc16_step = {1'b0, crc_in[15:1]} ^ (fb ? CRC_POLY_REFL : 16'h0000);
  endfunction

  // Line symbol for an NRZI level: lvl=1 is J, lvl=0 is K
  function automatic logic [1:0] line_sym(input logic ls, input logic lvl);
    logic [1:0] j_sym;
    j_sym    = ls ? 2'b01 : 2'b10;
    line_sym = lvl ? j_sym : ~j_sym;
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  clk_cnt_r, clk_cnt_s;
  logic [3:0]  bit_cnt_r, bit_cnt_s;
  logic [7:0]  shift_r, shift_s;
  logic [15:0] crc_r, crc_s;
  logic [2:0]  ones_r, ones_s;
  logic        lvl_r, lvl_s;
  logic        ls_r, ls_s;
  logic        crc_en_r, crc_en_s;
  logic        pid_r, pid_s;
  logic [1:0]  d_o_r, d_o_s;
  logic        d_en_r, d_en_s;

  logic        ready_s;
  logic [7:0]  bit_last_s;
  logic        tick_s;
  logic        emit_s;
  logic        bit_s;
  logic        crc_upd_s;
  logic        load_s;
  logic        goto_eop_s;

  // Next-state, bit selection, NRZI/stuffing and output symbol logic
  always_comb begin
    state_s    = state_r;
    clk_cnt_s  = clk_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    crc_s      = crc_r;
    ones_s     = ones_r;
    lvl_s      = lvl_r;
    ls_s       = ls_r;
    crc_en_s   = crc_en_r;
    pid_s      = pid_r;
    d_o_s      = d_o_r;
    d_en_s     = d_en_r;
    ready_s    = 1'b0;
    emit_s     = 1'b0;
    bit_s      = 1'b0;
    crc_upd_s  = 1'b0;
    load_s     = 1'b0;
    goto_eop_s = 1'b0;
    bit_last_s = ls_r ? LS_LAST : FS_LAST;
    tick_s     = (clk_cnt_r == bit_last_s);

    if (state_r == ST_IDLE) begin
      // Idle line is J of the live speed input; line level resets to J
      clk_cnt_s = 8'd0;
      bit_cnt_s = 4'd0;
      ones_s    = 3'd0;
      crc_s     = CRC_INIT;
      lvl_s     = 1'b1;
      d_en_s    = 1'b0;
      d_o_s     = line_sym(low_speed, 1'b1);
      if (valid) begin
        // First SYNC bit (0 -> K) goes out on this very edge
        state_s  = ST_SYNC;
        ls_s     = low_speed;
        crc_en_s = crc16 & CRC16_EN;
        pid_s    = 1'b0;
        d_en_s   = 1'b1;
        emit_s   = 1'b1;
        bit_s    = 1'b0;
      end else begin
        state_s = ST_IDLE;
      end
    end else if (!tick_s) begin
      clk_cnt_s = clk_cnt_r + 8'd1;
    end else begin
      // Bit boundary: pick the next symbol
      clk_cnt_s = 8'd0;
      if ((ones_r == STUFF_RUN) && (state_r != ST_EOP)) begin
        // Stuffed 0: bit position does not advance
        emit_s = 1'b1;
        bit_s  = 1'b0;
      end else begin
        case (state_r)
          ST_SYNC: begin
            if (bit_cnt_r != 4'd7) begin
              bit_cnt_s = bit_cnt_r + 4'd1;
              emit_s    = 1'b1;
              bit_s     = (bit_cnt_r == 4'd6);
            end else begin
              load_s = 1'b1;
            end
          end
          ST_DATA: begin
            if (bit_cnt_r != 4'd7) begin
              bit_cnt_s = bit_cnt_r + 4'd1;
              emit_s    = 1'b1;
              bit_s     = shift_r[bit_cnt_s[2:0]];
              crc_upd_s = ~pid_r;
            end else begin
              load_s = 1'b1;
            end
          end
          ST_CRC: begin
            if (bit_cnt_r != 4'd15) begin
              bit_cnt_s = bit_cnt_r + 4'd1;
              emit_s    = 1'b1;
              bit_s     = ~crc_r[bit_cnt_s];
            end else begin
              goto_eop_s = 1'b1;
            end
          end
          ST_EOP: begin
            if (bit_cnt_r != 4'd2) begin
              bit_cnt_s = bit_cnt_r + 4'd1;
              d_o_s     = (bit_cnt_r == 4'd1) ? line_sym(ls_r, 1'b1) : 2'b00;
            end else begin
              state_s   = ST_IDLE;
              d_en_s    = 1'b0;
              d_o_s     = line_sym(low_speed, 1'b1);
              bit_cnt_s = 4'd0;
              lvl_s     = 1'b1;
              ones_s    = 3'd0;
            end
          end
          default: begin
            state_s = ST_IDLE;
            d_en_s  = 1'b0;
          end
        endcase
      end
    end

    // Byte boundary: take the next byte, or close the packet
    if (load_s) begin
      if (valid) begin
        ready_s   = 1'b1;
        shift_s   = data;
        pid_s     = (state_r == ST_SYNC);
        state_s   = ST_DATA;
        bit_cnt_s = 4'd0;
        emit_s    = 1'b1;
        bit_s     = data[0];
        crc_upd_s = (state_r != ST_SYNC);
      end else if (crc_en_r) begin
        state_s   = ST_CRC;
        bit_cnt_s = 4'd0;
        emit_s    = 1'b1;
        bit_s     = ~crc_r[0];
      end else begin
        goto_eop_s = 1'b1;
      end
    end else begin
      ready_s = 1'b0;
    end

    if (goto_eop_s) begin
      state_s   = ST_EOP;
      bit_cnt_s = 4'd0;
      ones_s    = 3'd0;
      d_o_s     = 2'b00;
    end else begin
      d_en_s = d_en_s;
    end

    // NRZI encode the chosen bit and track the run of ones
    if (emit_s) begin
      ones_s = bit_s ? (ones_r + 3'd1) : 3'd0;
      lvl_s  = bit_s ? lvl_r : ~lvl_r;
      d_o_s  = line_sym(ls_s, lvl_s);
      if (crc_upd_s) begin
        crc_s = crc16_step(crc_r, bit_s);
      end else begin
        crc_s = crc_s;
      end
    end else begin
      ones_s = ones_s;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      clk_cnt_r <= 8'd0;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'd0;
      crc_r     <= CRC_INIT;
      ones_r    <= 3'd0;
      lvl_r     <= 1'b1;
      ls_r      <= 1'b0;
      crc_en_r  <= 1'b0;
      pid_r     <= 1'b0;
      d_o_r     <= line_sym(low_speed, 1'b1);
      d_en_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      clk_cnt_r <= clk_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      crc_r     <= crc_s;
      ones_r    <= ones_s;
      lvl_r     <= lvl_s;
      ls_r      <= ls_s;
      crc_en_r  <= crc_en_s;
      pid_r     <= pid_s;
      d_o_r     <= d_o_s;
      d_en_r    <= d_en_s;
    end
  end

  // ready is qualified by valid in the same clk, so it cannot be registered
  assign ready = ready_s;
  assign d_o   = d_o_r;
  assign d_en  = d_en_r;

endmodule

// File: tb/tb_usb_tx_lsfs.sv
// tb_usb_tx_lsfs: randomized scoreboard bench for usb_tx_lsfs.
// The driver builds the expected line symbol stream from the packet bytes
// (bit list, CRC, stuffing, NRZI) and queues it; the monitor captures each
// d_en window, compares it symbol-by-symbol and decodes the CRC residual.

module tb_usb_tx_lsfs;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       low_speed;
  logic       crc16;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [1:0] d_o;
  logic       d_en;

  int total = 0;
  int bad   = 0;

  int         exp_len_q[$];
  bit         exp_ls_q[$];
  bit         exp_crc_q[$];
  logic [1:0] exp_sym_q[$];
  logic [7:0] pkt[$];

  always #5 clk = ~clk;

  usb_tx_lsfs #(.CLKS_PER_BIT(CPB), .CRC16_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .low_speed(low_speed), .crc16(crc16),
    .data(data), .valid(valid), .ready(ready), .d_o(d_o), .d_en(d_en)
  );

  function automatic logic [1:0] jsym(input bit ls);
    return ls ? 2'b01 : 2'b10;
  endfunction

  // MSB-first CRC16 (0x8005), the textbook shift-left form
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input bit b);
    bit fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference encoder: packet bytes -> expected symbol stream
  task automatic push_expected(input bit ls, input bit crc);
    bit         bits[$];
    bit         stf[$];
    int         ones;
    logic [15:0] c;
    bit         lvl;
    logic [1:0] j;
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    c = 16'hFFFF;
    foreach (pkt[k]) begin
      for (int b = 0; b < 8; b++) begin
        bits.push_back(pkt[k][b]);
        if (k > 0) c = crc_ref(c, pkt[k][b]);
      end
    end
    if (crc) for (int b = 15; b >= 0; b--) bits.push_back(~c[b]);
    ones = 0;
    foreach (bits[i]) begin
      stf.push_back(bits[i]);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        stf.push_back(1'b0);
        ones = 0;
      end
    end
    j = jsym(ls);
    lvl = 1'b1;
    foreach (stf[i]) begin
      if (!stf[i]) lvl = ~lvl;
      exp_sym_q.push_back(lvl ? j : ~j);
    end
    exp_sym_q.push_back(2'b00);
    exp_sym_q.push_back(2'b00);
    exp_sym_q.push_back(j);
    exp_len_q.push_back(stf.size() + 3);
    exp_ls_q.push_back(ls);
    exp_crc_q.push_back(crc);
  endtask

  // Drive one packet from pkt[]; abort_clks>0 resets the DUT mid-packet
  task automatic send_pkt(input bit ls, input bit crc, input int abort_clks);
    int idx, rdy, cyc, since;
    bit seen;
    if (abort_clks == 0) begin
      push_expected(ls, crc);
    end else begin
      exp_len_q.push_back(-1);
      exp_ls_q.push_back(ls);
      exp_crc_q.push_back(crc);
    end
    idx = 0; rdy = 0; cyc = 0; since = 0; seen = 1'b0;
    @(negedge clk);
    low_speed = ls;
    crc16 = crc;
    forever begin
      if (idx < pkt.size()) begin
        valid = 1'b1;
        data  = pkt[idx];
      end else begin
        valid = 1'b0;
        data  = 8'($urandom);
      end
      if (seen) begin
        low_speed = 1'($urandom_range(0, 1));
        crc16     = 1'($urandom_range(0, 1));
      end
      #1;
      if (ready === 1'b1) begin
        rdy++;
        idx++;
      end
      if (d_en === 1'b1) seen = 1'b1;
      if (abort_clks > 0 && rdy > 0) begin
        since++;
        if (since == abort_clks) begin
          reset = 1'b0;
          valid = 1'b0;
          @(posedge clk);
          #1;
          check("abort_d_en", d_en, 0);
          check("abort_ready", ready, 0);
          @(negedge clk);
          reset = 1'b1;
          low_speed = ls;
          crc16 = crc;
          return;
        end
      end
      if (seen && idx >= pkt.size() && d_en === 1'b0) break;
      cyc++;
      if (cyc > 30000) begin
        check("packet_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    low_speed = ls;
    crc16 = crc;
    valid = 1'b0;
    check("ready_pulses", rdy, pkt.size());
    repeat (2) @(negedge clk);
    check("idle_d_en", d_en, 0);
    check("idle_j", d_o, jsym(ls));
  endtask

  // Monitor: capture each d_en window and compare against the scoreboard
  initial begin : monitor
    logic [1:0] smp[$];
    logic [1:0] esym[$];
    logic [1:0] prev, s;
    logic [15:0] r;
    int len, L, bad_bit, ones, nbits;
    bit ls, crc, bv;
    forever begin
      @(negedge clk);
      if (d_en === 1'b1) begin
        smp = {};
        while (d_en === 1'b1 && smp.size() < 40000) begin
          smp.push_back(d_o);
          @(negedge clk);
        end
        if (exp_len_q.size() == 0) begin
          check("unexpected_packet", smp.size(), 0);
        end else begin
          len = exp_len_q.pop_front();
          ls  = exp_ls_q.pop_front();
          crc = exp_crc_q.pop_front();
          if (len >= 0) begin
            L = ls ? 8 * CPB : CPB;
            check("d_en_clks", smp.size(), len * L);
            esym = {};
            repeat (len) esym.push_back(exp_sym_q.pop_front());
            bad_bit = -1;
            for (int i = 0; i < len && bad_bit < 0; i++) begin
              for (int k = 0; k < L; k++) begin
                if (i * L + k >= smp.size() || smp[i * L + k] !== esym[i]) begin
                  bad_bit = i;
                  break;
                end
              end
            end
            total++;
            if (bad_bit >= 0) begin
              bad++;
              $display("FAIL symbol_stream actual=wrong symbol at bit %0d required=%b held %0d clks",
                       bad_bit, esym[bad_bit], L);
            end
            if (crc) begin
              r = 16'hFFFF; prev = jsym(ls); ones = 0; nbits = 0;
              for (int i = 0; i < smp.size() / L - 3; i++) begin
                s = smp[i * L + L / 2];
                bv = (s == prev);
                prev = s;
                if (ones == 6) begin
                  ones = 0;
                  continue;
                end
                ones = bv ? ones + 1 : 0;
                if (nbits >= 16) r = crc_ref(r, bv);
                nbits++;
              end
              check("crc_residual", r, 16'h800D);
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; valid = 1'b0; data = 8'h00; low_speed = 1'b0; crc16 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_d_en", d_en, 0);
    check("reset_ready", ready, 0);
    check("reset_d_o", d_o, 2'b10);
    valid = 1'b1;
    @(negedge clk);
    check("reset_blocks_start", d_en, 0);
    valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", d_en, 0);

    pkt = {8'hC3};
    send_pkt(1'b0, 1'b0, 0);
    pkt = {8'hC3};
    send_pkt(1'b0, 1'b1, 0);
    pkt = {8'hFF};
    send_pkt(1'b0, 1'b0, 0);

    low_speed = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_j_ls", d_o, 2'b01);
    pkt = {};
    repeat (3) pkt.push_back(8'($urandom));
    send_pkt(1'b1, 1'b0, 0);

    pkt = {};
    repeat (4) pkt.push_back(8'($urandom));
    send_pkt(1'b0, 1'b1, 10);
    pkt = {8'hC3, 8'hFF, 8'h7E, 8'($urandom)};
    send_pkt(1'b0, 1'b1, 0);

    pkt = {8'h4B};
    repeat (31) pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
    send_pkt(1'b0, 1'b1, 0);

    for (int p = 0; p < 8; p++) begin
      int n;
      n = $urandom_range(1, 6);
      pkt = {};
      repeat (n) pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      send_pkt(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_len_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_tx_lsfs.md
USB_TX_LSFS -- requirements
Module: usb_tx_lsfs

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, meaning clk cycles per full-speed bit time; legal values 2 to 16.
REQ-002 Parameter CRC16_EN, default 1, meaning CRC16 append logic is present; when 0, the crc16 input is ignored.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 low_speed  input  1  1 selects low-speed mode; sampled only at packet start.
REQ-006 crc16  input  1  1 appends CRC16 after the last byte; sampled only at packet start.
REQ-007 data  input  8  byte to transmit, LSB first.
REQ-008 valid  input  1  a byte is available on data.
REQ-009 ready  output  1  one-clk pulse: data is captured at this edge; next byte is due.
REQ-010 d_o  output  2  line symbol {dp, dm}.
REQ-011 d_en  output  1  output-driver enable.

Function
REQ-012 Bit time SHALL be CLKS_PER_BIT clks (full speed) or 8*CLKS_PER_BIT clks (low speed); every line symbol SHALL be held exactly one bit time.
REQ-013 Symbols: J = 10 at FS, 01 at LS; K = inverse of J; SE0 = 00.
REQ-014 States: IDLE, SYNC, DATA, CRC, EOP. IDLE exits to SYNC when valid=1; on that edge low_speed and crc16 are latched.
REQ-015 SYNC SHALL send the NRZI encoding of 8'b00000001, giving KJKJKJKK; d_en rises with the first K, with no extra delay cycle.
REQ-016 NRZI: a 0 bit toggles the line; a 1 bit holds it; the line state entering SYNC is J.
REQ-017 Byte load occurs in the clk before the first bit of each byte. If valid=1, the byte is loaded and ready=1 for exactly that clk. If valid=0, no byte is loaded, ready stays 0, and the FSM goes to CRC (if latched crc16=1 and CRC16_EN=1) or to EOP.
REQ-018 The first byte load SHALL occur during the last bit of SYNC; the first data bit follows SYNC back-to-back.
REQ-019 Bit stuffing: after six consecutive 1 bits, a 0 SHALL be inserted. The count includes the final SYNC bit and spans byte and CRC boundaries. A stuffed bit resets the count. A stuffed bit is inserted even if it follows the last data or CRC bit. No byte load occurs during a stuffed bit.
REQ-020 CRC16: polynomial x^16+x^15+x^2+1, initialised to FFFF on entry to SYNC. It covers every byte after the first loaded byte (the PID is excluded). It is sent as the ones-complement of the remainder, LSB first, NRZI-encoded and stuffed.
REQ-021 EOP: SE0 for 2 bit times, then J for 1 bit time. d_en then falls and the FSM returns to IDLE. valid is ignored during CRC and EOP.
REQ-022 In IDLE: d_en=0 and d_o=J of the current low_speed input.
REQ-023 Changes to low_speed or crc16 during a packet SHALL have no effect until the next packet.

Reset
REQ-024 When reset=0 at a clk edge, the block SHALL enter IDLE on that edge. Resulting values: d_en=0, ready=0, bit counters cleared, stuff count 0, CRC register FFFF.
REQ-025 A reset mid-packet SHALL abort the packet immediately, with no EOP.
REQ-026 The first valid seen after reset releases SHALL start a full SYNC.

Verification
REQ-027 FS, CLKS_PER_BIT=4, crc16=0; valid=1 with data C3, then valid=0 -> KJKJKJKK, NRZI bits of 11000011, SE0 SE0 J. Each symbol lasts 4 clks; exactly one ready pulse.
REQ-028 FS, crc16=1; PID C3 only (zero-length DATA0) -> after the PID, 16 CRC bits all 0 (complement of FFFF), then EOP; total 8+8+16+3 bit times = 140 clks of d_en=1.
REQ-029 FS; data FF, then valid=0 -> a stuffed 0 (line toggle) after the 5th data bit, counted with the final SYNC 1. Total data-phase length 9 bit times.
REQ-030 LS, CLKS_PER_BIT=4; 3 random bytes -> each symbol lasts 32 clks; idle and EOP J = 01. ready pulses 3 times, spaced 8 bit times apart, plus stuff bits.
REQ-031 Reset=0 asserted mid-byte in DATA -> next clk d_en=0, ready=0. After release with valid=1, a clean SYNC starts.
REQ-032 Random byte stream of 30+ bytes, crc16=1 -> a bit-accurate reference decoder (NRZI, destuff, CRC check) recovers every byte and reports CRC residual 800D.
